// File: rtl/tx_ctrl_module.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bits.
// Ports: CLOCK/RST_n, TX_En_Sig/TX_Data request, BPS_CLKen bit strobe in,
//   Bps_En_Sig baud enable, TX_Busy, TX_Done_Sig pulse, TX_Pin_Out line.
module tx_ctrl_module #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLOCK,
  input  logic                 RST_n,
  input  logic                 TX_En_Sig,
  input  logic [DATA_BITS-1:0] TX_Data,
  input  logic                 BPS_CLKen,
  output logic                 Bps_En_Sig,
  output logic                 TX_Busy,
  output logic                 TX_Done_Sig,
  output logic                 TX_Pin_Out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYNC  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_PAR   = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != 0);
  localparam bit         ODD_PAR   = (PARITY == 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  // Low in the SYNC entry cycle so a stale strobe is dropped.
  logic                 armed;

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      par_bit     <= 1'b0;
      bit_cnt     <= 4'd0;
      stop_cnt    <= 1'b0;
      armed       <= 1'b0;
      Bps_En_Sig  <= 1'b0;
      TX_Busy     <= 1'b0;
      TX_Done_Sig <= 1'b0;
      TX_Pin_Out  <= 1'b1;
    end else begin
      TX_Done_Sig <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (TX_En_Sig) begin
            shreg      <= TX_Data;
            par_bit    <= ODD_PAR ? ~^TX_Data : ^TX_Data;
            armed      <= 1'b0;
            state      <= S_SYNC;
            TX_Busy    <= 1'b1;
            Bps_En_Sig <= 1'b1;
          end
        end
        S_SYNC: begin
          if (armed && BPS_CLKen) begin
            state      <= S_START;
            TX_Pin_Out <= 1'b0;
          end else begin
            armed <= 1'b1;
          end
        end
        S_START: begin
          if (BPS_CLKen) begin
            state      <= S_DATA;
            bit_cnt    <= 4'd0;
            TX_Pin_Out <= shreg[0];
          end
        end
        S_DATA: begin
          if (BPS_CLKen) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              if (HAS_PAR) begin
                state      <= S_PAR;
                TX_Pin_Out <= par_bit;
              end else begin
                state      <= S_STOP;
                stop_cnt   <= 1'b0;
                TX_Pin_Out <= 1'b1;
              end
            end else begin
              TX_Pin_Out <= shreg[1];
            end
          end
        end
        S_PAR: begin
          if (BPS_CLKen) begin
            state      <= S_STOP;
            stop_cnt   <= 1'b0;
            TX_Pin_Out <= 1'b1;
          end
        end
        S_STOP: begin
          if (BPS_CLKen) begin
            if (stop_cnt == LAST_STOP) begin
              state       <= S_IDLE;
              TX_Busy     <= 1'b0;
              Bps_En_Sig  <= 1'b0;
              TX_Done_Sig <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          TX_Busy    <= 1'b0;
          Bps_En_Sig <= 1'b0;
          TX_Pin_Out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_ctrl_module.sv
// Bench for tx_ctrl_module: four parameter sets driven with table,
// hand-written and random frames; 16-cycle bit strobes.
module tb_tx_ctrl_module;

  localparam int DBS  [4] = '{8, 8, 8, 5};
  localparam int PARS [4] = '{0, 2, 1, 2};
  localparam int STPS [4] = '{1, 2, 1, 1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en;
  logic [3:0] stb;
  logic [7:0] data [4];
  logic [3:0] line, bps, busy, done;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = DBS[g];
    tx_ctrl_module #(
      .DATA_BITS(DBS[g]),
      .PARITY   (PARS[g]),
      .STOP_BITS(STPS[g])
    ) dut (
      .CLOCK      (clk),
      .RST_n      (rst_n),
      .TX_En_Sig  (en[g]),
      .TX_Data    (data[g][W-1:0]),
      .BPS_CLKen  (stb[g]),
      .Bps_En_Sig (bps[g]),
      .TX_Busy    (busy[g]),
      .TX_Done_Sig(done[g]),
      .TX_Pin_Out (line[g])
    );
  end

  typedef struct {
    int          g;
    logic [7:0]  d;
    logic [15:0] f;
    int          len;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, int g, int c, logic act, logic exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc%0d got %b want %b", nm, g, c, act, exp);
    end
  endtask

  // Frame bits in transmit order, bit 0 first.
  function automatic void frame_of(int g, logic [7:0] d,
                                   output logic [15:0] f,
                                   output int len);
    int ones;
    ones = 0;
    f    = '0;
    len  = 1;
    for (int i = 0; i < DBS[g]; i++) begin
      f[len] = d[i];
      ones  += int'(d[i]);
      len++;
    end
    if (PARS[g] != 0) begin
      f[len] = (PARS[g] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      len++;
    end
    for (int i = 0; i < STPS[g]; i++) begin
      f[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic idle_chk(int g, int c);
    chk("line", g, c, line[g], 1'b1);
    chk("busy", g, c, busy[g], 1'b0);
    chk("bps",  g, c, bps[g],  1'b0);
    chk("done", g, c, done[g], 1'b0);
  endtask

  task automatic do_reset(int g);
    #3 rst_n = 1'b0;
    #1;
    idle_chk(g, -1);
    stb = '0;
    en  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idle_chk(g, c);
    end
  endtask

  // Bit n-1 of the frame is on the line after n counted strobes;
  // the strobe count reaches len+1 at the final stop strobe.
  task automatic send(int g, logic [7:0] d, logic [15:0] f, int len,
                      bit hold, bit already, bit mid, bit stale,
                      int abort_at);
    int   n;
    logic el;
    n = 0;
    if (!already) begin
      @(negedge clk);
      en[g]   = 1'b1;
      data[g] = d;
    end
    for (int c = 1; c <= 16 * (len + 1) + 1; c++) begin
      @(negedge clk);
      el = (n == 0 || n > len) ? 1'b1 : f[n-1];
      chk("line", g, c, line[g], el);
      chk("busy", g, c, busy[g], n <= len);
      chk("bps",  g, c, bps[g],  n <= len);
      chk("done", g, c, done[g], n == len + 1);
      if (n == len + 1) break;
      if (c == abort_at) begin
        do_reset(g);
        return;
      end
      if (c == 1 && !hold) en[g] = 1'b0;
      if (mid && c == 40) begin
        en[g]   = 1'b1;
        data[g] = 8'hFF;
      end
      if (mid && c == 41) en[g] = 1'b0;
      stb[g] = (c % 16 == 0) || (stale && c == 1);
      if (stb[g] && c > 1) n++;
    end
    stb[g] = 1'b0;
    if (!hold) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        idle_chk(g, 1000 + c);
      end
    end
  endtask

  initial begin
    logic [15:0] f;
    int          len;
    int          g;
    logic [7:0]  d;

    tbl[0] = '{0, 8'h55, 16'h02AA, 10};
    tbl[1] = '{0, 8'h00, 16'h0200, 10};
    tbl[2] = '{0, 8'hFF, 16'h03FE, 10};
    tbl[3] = '{1, 8'h07, 16'h0E0E, 12};
    tbl[4] = '{1, 8'hA3, 16'h0D46, 12};
    tbl[5] = '{2, 8'h07, 16'h040E, 11};
    tbl[6] = '{2, 8'h55, 16'h06AA, 11};
    tbl[7] = '{3, 8'h13, 16'h00E6, 8};
    tbl[8] = '{3, 8'h0A, 16'h0094, 8};

    rst_n = 1'b1;
    en    = '0;
    stb   = '0;
    for (int i = 0; i < 4; i++) data[i] = '0;
    #2 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) idle_chk(i, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      send(tbl[i].g, tbl[i].d, tbl[i].f, tbl[i].len, 0, 0, 0, 0, 0);

    send(1, 8'hA3, 16'h0D46, 12, 1, 0, 0, 0, 0);
    send(1, 8'hA3, 16'h0D46, 12, 0, 1, 0, 0, 0);

    send(0, 8'h00, 16'h0200, 10, 0, 0, 1, 0, 0);

    send(0, 8'h00, 16'h0200, 10, 0, 0, 0, 0, 88);
    send(0, 8'h5A, 16'h02B4, 10, 0, 0, 0, 0, 0);

    frame_of(0, 8'h3C, f, len);
    send(0, 8'h3C, f, len, 0, 0, 0, 1, 0);
    frame_of(3, 8'h1B, f, len);
    send(3, 8'h1B, f, len, 0, 0, 0, 1, 0);

    for (int i = 0; i < 16; i++) begin
      g = int'($urandom_range(3, 0));
      d = 8'($urandom);
      frame_of(g, d, f, len);
      send(g, d, f, len, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
